// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has absolute priority,
// multi-cycle results wait in an in-order FIFO and drain into idle slots.
module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  pipe_addr_i,
    input  logic [31:0] pipe_data_i,
    input  logic        pipe_valid_i,
    input  logic [4:0]  mc_addr_i,
    input  logic [31:0] mc_data_i,
    input  logic        mc_valid_i,
    output logic        mc_ready_o,
    output logic [4:0]  wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic        wr_valid_o,
    output logic        wr_src_o,
    output logic [31:0] pending_mask_o,
    output logic        stall_req_o,
    output logic        empty_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       mem_addr_q [FIFO_DEPTH];
    logic [31:0]      mem_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, offset;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       starve_q, starve_d;
    logic             wr_valid_q, wr_valid_d, wr_src_q, wr_src_d;
    logic [4:0]       wr_addr_q, wr_addr_d;
    logic [31:0]      wr_data_q, wr_data_d, mask;
    logic             slot_busy, fifo_empty, push, pop;

    always_comb begin
        slot_busy  = pipe_valid_i && (pipe_addr_i != 5'd0);
        fifo_empty = (count_q == '0);
        mc_ready_o = !reset_i && (count_q != CNT_W'(FIFO_DEPTH));
        // A result for x0 is still handshaken, it just never occupies a slot.
        push       = mc_valid_i && mc_ready_o && (mc_addr_i != 5'd0);
        pop        = !slot_busy && !fifo_empty;

        wr_valid_d = slot_busy || pop;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_src_d   = wr_src_q;
        if (slot_busy) begin
            wr_addr_d = pipe_addr_i;
            wr_data_d = pipe_data_i;
            wr_src_d  = 1'b0;
        end else if (pop) begin
            wr_addr_d = mem_addr_q[rd_ptr_q];
            wr_data_d = mem_data_q[rd_ptr_q];
            wr_src_d  = 1'b1;
        end

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);

        if (fifo_empty || pop)
            starve_d = 8'd0;
        else if (starve_q != 8'hFF)
            starve_d = starve_q + 8'd1;
        else
            starve_d = starve_q;
    end

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        mask   = 32'd0;
        offset = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q)
                mask[mem_addr_q[i]] = 1'b1;
        end
        mask[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= 8'd0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 32'd0;
            wr_src_q   <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= mc_addr_i;
            mem_data_q[wr_ptr_q] <= mc_data_i;
        end
    end

    assign wr_valid_o     = wr_valid_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign wr_src_o       = wr_src_q;
    assign pending_mask_o = mask;
    assign empty_o        = fifo_empty;
    assign stall_req_o    = (starve_q >= 8'(STARVE_LIMIT));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then random traffic
// against a queue-based model of the arbitration rules.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset_i, pipe_valid_i, mc_valid_i;
    logic [4:0]  pipe_addr_i, mc_addr_i;
    logic [31:0] pipe_data_i, mc_data_i;
    logic        mc_ready_o, wr_valid_o, wr_src_o, stall_req_o, empty_o;
    logic [4:0]  wr_addr_o;
    logic [31:0] wr_data_o, pending_mask_o;

    regfile_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i), .pipe_valid_i(pipe_valid_i),
        .mc_addr_i(mc_addr_i), .mc_data_i(mc_data_i), .mc_valid_i(mc_valid_i),
        .mc_ready_o(mc_ready_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .wr_valid_o(wr_valid_o), .wr_src_o(wr_src_o), .pending_mask_o(pending_mask_o),
        .stall_req_o(stall_req_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_ready, e_v;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_src, e_empty;
        logic [31:0] e_mask;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_starve = 0;
    logic m_v = 0, m_src = 0, ready_seen;
    logic [4:0]  m_a = 0;
    logic [31:0] m_d = 0;

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic pv, input logic [4:0] pa,
                                input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                                input logic [31:0] md, input logic ready, input logic v,
                                input logic [4:0] a, input logic [31:0] d, input logic src,
                                input logic empty, input logic [31:0] mask, input logic stall);
        vec_t t;
        t.rst = rst; t.pv = pv; t.pa = pa; t.pd = pd; t.mv = mv; t.ma = ma; t.md = md;
        t.e_ready = ready; t.e_v = v; t.e_a = a; t.e_d = d; t.e_src = src;
        t.e_empty = empty; t.e_mask = mask; t.e_stall = stall;
        vecs.push_back(t);
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = 32'd0;
        foreach (mq[i]) m |= (32'd1 << mq[i].a);
        return m & ~32'd1;
    endfunction

    // One clock: drive, check ready before the edge, advance the model, check after.
    task automatic step(input int tag, input logic r, input logic pv, input logic [4:0] pa,
                        input logic [31:0] pd, input logic mv, input logic [4:0] ma,
                        input logic [31:0] md);
        logic exp_ready, busy, pop;
        int   pre;
        ent_t e;
        reset_i = r; pipe_valid_i = pv; pipe_addr_i = pa; pipe_data_i = pd;
        mc_valid_i = mv; mc_addr_i = ma; mc_data_i = md;
        #1;
        exp_ready = !r && (mq.size() != DEPTH);
        ready_seen = mc_ready_o;
        chk("mc_ready", tag, {31'd0, mc_ready_o}, {31'd0, exp_ready});
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_starve = 0; m_v = 0; m_a = 0; m_d = 0; m_src = 0;
        end else begin
            busy = pv && (pa != 0);
            pre  = mq.size();
            pop  = !busy && pre > 0;
            m_v  = busy || pop;
            if (busy) begin
                m_a = pa; m_d = pd; m_src = 0;
            end else if (pop) begin
                e = mq.pop_front();
                m_a = e.a; m_d = e.d; m_src = 1;
            end
            m_starve = (pre == 0 || pop) ? 0 : ((m_starve < 255) ? m_starve + 1 : 255);
            if (mv && exp_ready && ma != 0) begin
                e.a = ma; e.d = md;
                mq.push_back(e);
            end
        end
        #1;
        chk("wr_valid", tag, {31'd0, wr_valid_o}, {31'd0, m_v});
        chk("wr_addr", tag, {27'd0, wr_addr_o}, {27'd0, m_a});
        chk("wr_data", tag, wr_data_o, m_d);
        chk("wr_src", tag, {31'd0, wr_src_o}, {31'd0, m_src});
        chk("pending", tag, pending_mask_o, model_mask());
        chk("empty", tag, {31'd0, empty_o}, {31'd0, (mq.size() == 0)});
        chk("stall", tag, {31'd0, stall_req_o}, {31'd0, (m_starve >= LIMIT)});
    endtask

    initial begin
        //  rst pv pa  pd        mv ma  md           rdy v  a  d            src emp mask        stall
        add(1, 0, 0,  0,         0, 0,  0,           0,  0, 0, 0,           0,  1,  0,          0);
        add(0, 1, 5,  32'h1234,  0, 0,  0,           1,  1, 5, 32'h1234,    0,  1,  0,          0);
        add(0, 1, 0,  32'hFFFF,  0, 0,  0,           1,  0, 5, 32'h1234,    0,  1,  0,          0);
        add(0, 0, 0,  0,         1, 7,  32'hDEAD,    1,  0, 5, 32'h1234,    0,  0,  32'h80,     0);
        add(0, 0, 0,  0,         0, 0,  0,           1,  1, 7, 32'hDEAD,    1,  1,  0,          0);
        add(0, 0, 0,  0,         0, 0,  0,           1,  0, 7, 32'hDEAD,    1,  1,  0,          0);
        add(0, 0, 0,  0,         1, 0,  32'h55,      1,  0, 7, 32'hDEAD,    1,  1,  0,          0);
        add(0, 1, 9,  32'h99,    1, 3,  32'h33,      1,  1, 9, 32'h99,      0,  0,  32'h8,      0);
        add(0, 1, 10, 32'hA,     1, 4,  32'h44,      1,  1, 10, 32'hA,      0,  0,  32'h18,     0);
        add(0, 1, 11, 32'hB,     1, 5,  32'h55,      0,  1, 11, 32'hB,      0,  0,  32'h18,     0);
        add(0, 0, 0,  0,         0, 0,  0,           0,  1, 3, 32'h33,      1,  0,  32'h10,     0);
        add(0, 0, 0,  0,         0, 0,  0,           1,  1, 4, 32'h44,      1,  1,  0,          0);
        add(0, 1, 1,  32'h1,     1, 6,  32'h66,      1,  1, 1, 32'h1,       0,  0,  32'h40,     0);
        for (int k = 0; k < 7; k++)
            add(0, 1, 1, 32'h1,  0, 0,  0,           1,  1, 1, 32'h1,       0,  0,  32'h40,     0);
        add(0, 1, 1,  32'h1,     0, 0,  0,           1,  1, 1, 32'h1,       0,  0,  32'h40,     1);
        add(0, 0, 0,  0,         0, 0,  0,           1,  1, 6, 32'h66,      1,  1,  0,          0);
        add(0, 1, 2,  32'h2,     1, 8,  32'h88,      1,  1, 2, 32'h2,       0,  0,  32'h100,    0);
        add(0, 1, 2,  32'h2,     1, 9,  32'h99,      1,  1, 2, 32'h2,       0,  0,  32'h300,    0);
        add(1, 0, 0,  0,         1, 12, 32'hC,       0,  0, 0, 0,           0,  1,  0,          0);
        add(0, 0, 0,  0,         0, 0,  0,           1,  0, 0, 0,           0,  1,  0,          0);
        add(0, 0, 0,  0,         0, 0,  0,           1,  0, 0, 0,           0,  1,  0,          0);

        foreach (vecs[i]) begin
            step(i, vecs[i].rst, vecs[i].pv, vecs[i].pa, vecs[i].pd,
                 vecs[i].mv, vecs[i].ma, vecs[i].md);
            chk("t_ready", i, {31'd0, ready_seen}, {31'd0, vecs[i].e_ready});
            chk("t_valid", i, {31'd0, wr_valid_o}, {31'd0, vecs[i].e_v});
            chk("t_addr", i, {27'd0, wr_addr_o}, {27'd0, vecs[i].e_a});
            chk("t_data", i, wr_data_o, vecs[i].e_d);
            chk("t_src", i, {31'd0, wr_src_o}, {31'd0, vecs[i].e_src});
            chk("t_empty", i, {31'd0, empty_o}, {31'd0, vecs[i].e_empty});
            chk("t_mask", i, pending_mask_o, vecs[i].e_mask);
            chk("t_stall", i, {31'd0, stall_req_o}, {31'd0, vecs[i].e_stall});
        end

        // Random traffic; pipeline load varies by phase so starvation is reached.
        for (int c = 0; c < 3000; c++) begin
            int busy_pct;
            logic r;
            case ((c / 100) % 3)
                0:       busy_pct = 30;
                1:       busy_pct = 70;
                default: busy_pct = 97;
            endcase
            r = ($urandom_range(0, 199) == 0);
            step(1000 + c, r, ($urandom_range(0, 99) < busy_pct), 5'($urandom_range(0, 31)),
                 $urandom, ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between the in-order pipeline writeback stream and the multi-cycle execution unit (divider/CSR) result stream. Pipeline writes always win; multi-cycle results are buffered in a small FIFO and drained into idle write slots, with a stall request raised if they starve. It sits between the writeback stage output and the register file, and exports a pending-register mask to hazard detection.

## Interface
- FIFO_DEPTH, 2, multi-cycle result buffer entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive no-drain cycles before stall_req_o; 1..255
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- pipe_addr_i  in  5 (regaddr_t)  pipeline writeback address
- pipe_data_i  in  32 (word_t)  pipeline writeback data
- pipe_valid_i  in  1  pipeline writeback valid; cannot be back-pressured
- mc_addr_i  in  5 (regaddr_t)  multi-cycle result address
- mc_data_i  in  32 (word_t)  multi-cycle result data
- mc_valid_i  in  1  multi-cycle result valid
- mc_ready_o  out  1  FIFO can accept a result
- wr_addr_o  out  5  register-file write address
- wr_data_o  out  32  register-file write data
- wr_valid_o  out  1  register-file write enable
- wr_src_o  out  1  0 = pipeline, 1 = multi-cycle
- pending_mask_o  out  32  bit r set while a buffered write to xr is queued
- stall_req_o  out  1  request front-end bubble so the FIFO can drain
- empty_o  out  1  FIFO empty

## Operation
- Pipeline slot busy = pipe_valid_i && pipe_addr_i != 0. Writes to x0 from either source never reach the port.
- Accept: mc_valid_i && mc_ready_o. mc_ready_o = !reset_i && (count != FIFO_DEPTH), combinational from registered count. Accepted result with mc_addr_i == 0 is consumed and discarded (no enqueue).
- Per-cycle arbitration, strict priority:
  - slot busy: register pipeline write, wr_src_o=0; FIFO holds.
  - slot free, FIFO non-empty: pop head, register it, wr_src_o=1.
  - otherwise wr_valid_o=0; wr_addr_o/wr_data_o hold last value.
- FIFO is in-order; push and pop in the same cycle permitted (count unchanged). No push when full.
- pending_mask_o: OR of one-hot(addr) over valid FIFO entries, registered-state derived; bit 0 always 0. Entry leaves mask the cycle its write appears on wr_*.
- No reordering between sources: a pipeline write to xr while xr is pending is written first, the buffered write later. Issue logic uses pending_mask_o to block WAW/RAW on pending registers; the arbiter does not check.
- Starvation counter (8 bits): increments each cycle FIFO non-empty and no pop; clears on pop or when empty; saturates. stall_req_o = counter ≥ STARVE_LIMIT; drops the cycle after the first pop.
- empty_o = (count == 0).

## Timing
- Reset (reset_i high at edge): FIFO flushed, count=0, counter=0; wr_valid_o=0, wr_addr_o=0, wr_data_o=0, wr_src_o=0, pending_mask_o=0, stall_req_o=0, empty_o=1; mc_ready_o=0 while reset_i high. Reset mid-operation discards buffered results.
- Pipeline path: inputs at edge N → wr_* valid after edge N, i.e. 1-cycle registered latency.
- Multi-cycle path: accepted at edge N, earliest pop at edge N+1 → minimum 2-cycle latency; no bypass around the FIFO.
- Full: mc_ready_o low; a pop at edge N re-raises mc_ready_o after N.
- pending bit for an address set after the accept edge; cleared after the pop edge.

## Test plan
- Pipeline only: pipe (x5, 0x1234) valid one cycle → wr_valid_o=1, wr_addr_o=5, wr_data_o=0x1234, wr_src_o=0 one cycle later; pipe x0 write → wr_valid_o=0.
- MC into idle slot: mc (x7, 0xDEAD) accepted at N, pipe idle → wr at N+1 edge with wr_src_o=1; pending_mask_o bit 7 high for exactly one cycle.
- Collision: pipe busy every cycle, push x3 then x4 → mc_ready_o=0 after second push; pipe idle one cycle → x3 written, mc_ready_o=1; next idle → x4; order preserved.
- Starvation: one entry queued, pipe busy 8 cycles → stall_req_o=1 after 8th cycle; pipe idles → pop, stall_req_o=0 next cycle.
- MC to x0 accepted → nothing enqueued, empty_o stays 1, no write.
- Reset with 2 entries queued → empty_o=1, pending_mask_o=0, no buffered write ever emitted.
